// File: rtl/wbuf_send_multi.sv
// Weight send engine: streams SRAM X words into one or more weight buffers,
// sequentially per channel or broadcast, with stride, stall and read-latency alignment.
module wbuf_send_multi #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NCH      = 6,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned STRIDE_W = 8,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                CLK,
    input  logic                RSTL,
    input  logic                PURGE,
    input  logic                WBUF_SEND,
    input  logic [ADDR_W-1:0]   BASE_ADDR,
    input  logic [CNT_W-1:0]    COUNT,
    input  logic [STRIDE_W-1:0] STRIDE,
    input  logic [NCH-1:0]      CH_MASK,
    input  logic                MODE,
    input  logic                MBUSYX,
    output logic [ADDR_W-1:0]   RADDRX,
    output logic                RCEBX,
    output logic                WBUF_EN,
    output logic [NCH-1:0]      WBUF_EN_CTRL,
    output logic                WBUF_BUSY,
    output logic                WBUF_DONE
);

    localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remain_q, remain_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NCH-1:0]      mask_q, mask_d;
    logic [NCH-1:0]      tag_q, tag_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic                mode_q, mode_d;
    logic [DRN_W-1:0]    drain_q, drain_d;
    logic [ADDR_W-1:0]   raddr_d;
    logic                rceb_d, busy_d, done_d, issue;
    logic [NCH-1:0]      low, rest;

    logic [RD_LAT-1:0]   pipe_en;
    logic [NCH-1:0]      pipe_tag [RD_LAT];

    // Next-state and registered-output logic; IDLE latches the request and
    // the first read shares the issue path through the *_d values.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        count_d  = count_q;
        mask_d   = mask_q;
        tag_d    = tag_q;
        stride_d = stride_q;
        mode_d   = mode_q;
        drain_d  = drain_q;
        raddr_d  = RADDRX;
        rceb_d   = 1'b1;
        busy_d   = WBUF_BUSY;
        done_d   = 1'b0;
        issue    = 1'b0;
        low      = '0;
        rest     = '0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (WBUF_SEND) begin
                    addr_d   = BASE_ADDR;
                    remain_d = COUNT;
                    count_d  = COUNT;
                    mask_d   = CH_MASK;
                    stride_d = STRIDE;
                    mode_d   = MODE;
                    busy_d   = 1'b1;
                    if (COUNT == '0 || CH_MASK == '0) begin
                        state_d = DRAIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        issue   = !MBUSYX;
                    end
                end
            end
            READ: issue = !MBUSYX;
            DRAIN: begin
                if (WBUF_DONE) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (drain_q == '0) begin
                    done_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            low     = mask_d & (~mask_d + NCH'(1));
            rest    = mask_d & ~low;
            tag_d   = mode_d ? mask_d : low;
            raddr_d = addr_d;
            rceb_d  = 1'b0;
            addr_d  = addr_d + ADDR_W'(stride_d);
            if (remain_d == CNT_W'(1)) begin
                if (mode_d || rest == '0) begin
                    state_d = DRAIN;
                    drain_d = DRN_W'(RD_LAT - 1);
                end else begin
                    mask_d   = rest;
                    remain_d = count_d;
                end
            end else begin
                remain_d = remain_d - CNT_W'(1);
            end
        end

        if (PURGE) begin
            state_d  = IDLE;
            addr_d   = '0;
            remain_d = '0;
            count_d  = '0;
            mask_d   = '0;
            tag_d    = '0;
            stride_d = '0;
            mode_d   = 1'b0;
            drain_d  = '0;
            raddr_d  = '0;
            rceb_d   = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            count_q   <= '0;
            mask_q    <= '0;
            tag_q     <= '0;
            stride_q  <= '0;
            mode_q    <= 1'b0;
            drain_q   <= '0;
            RADDRX    <= '0;
            RCEBX     <= 1'b1;
            WBUF_BUSY <= 1'b0;
            WBUF_DONE <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            count_q   <= count_d;
            mask_q    <= mask_d;
            tag_q     <= tag_d;
            stride_q  <= stride_d;
            mode_q    <= mode_d;
            drain_q   <= drain_d;
            RADDRX    <= raddr_d;
            RCEBX     <= rceb_d;
            WBUF_BUSY <= busy_d;
            WBUF_DONE <= done_d;
        end
    end

    // Read-latency delay line: buffer strobe lines up with returning SRAM data.
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            pipe_en <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_tag[i] <= '0;
        end else if (PURGE) begin
            pipe_en <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_en[0]  <= ~RCEBX;
            pipe_tag[0] <= RCEBX ? '0 : tag_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_en[i]  <= pipe_en[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign WBUF_EN      = pipe_en[RD_LAT-1];
    assign WBUF_EN_CTRL = pipe_tag[RD_LAT-1];

endmodule

// File: tb/tb_wbuf_send_multi.sv
// Directed bench for wbuf_send_multi: sequential, broadcast, wrap, stall,
// degenerate, ignored request, purge and asynchronous reset.
module tb_wbuf_send_multi;

    logic        CLK = 1'b0;
    logic        RSTL = 1'b0;
    logic        PURGE = 1'b0;
    logic        WBUF_SEND = 1'b0;
    logic [15:0] BASE_ADDR = '0;
    logic [7:0]  COUNT = '0;
    logic [7:0]  STRIDE = '0;
    logic [5:0]  CH_MASK = '0;
    logic        MODE = 1'b0;
    logic        MBUSYX = 1'b0;
    logic [15:0] RADDRX;
    logic        RCEBX;
    logic        WBUF_EN;
    logic [5:0]  WBUF_EN_CTRL;
    logic        WBUF_BUSY;
    logic        WBUF_DONE;

    int errors = 0;
    int checks = 0;

    wbuf_send_multi #(
        .ADDR_W(16), .NCH(6), .CNT_W(8), .STRIDE_W(8), .RD_LAT(1)
    ) dut (
        .CLK(CLK), .RSTL(RSTL), .PURGE(PURGE), .WBUF_SEND(WBUF_SEND),
        .BASE_ADDR(BASE_ADDR), .COUNT(COUNT), .STRIDE(STRIDE),
        .CH_MASK(CH_MASK), .MODE(MODE), .MBUSYX(MBUSYX),
        .RADDRX(RADDRX), .RCEBX(RCEBX), .WBUF_EN(WBUF_EN),
        .WBUF_EN_CTRL(WBUF_EN_CTRL), .WBUF_BUSY(WBUF_BUSY), .WBUF_DONE(WBUF_DONE)
    );

    always #5 CLK = ~CLK;

    // Drives a request during cycle T (between the next two rising edges).
    task automatic send(input logic [15:0] base, input logic [7:0] cnt,
                        input logic [7:0] str, input logic [5:0] mask, input logic mode);
        @(negedge CLK);
        BASE_ADDR = base; COUNT = cnt; STRIDE = str; CH_MASK = mask; MODE = mode;
        WBUF_SEND = 1'b1;
    endtask

    // Disturbs request inputs after acceptance; the engine must ignore them.
    task automatic scramble();
        WBUF_SEND = 1'b0; BASE_ADDR = 16'hDEAD; COUNT = 8'd9; STRIDE = 8'd7;
        CH_MASK = 6'b111010; MODE = ~MODE;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (RCEBX !== 1'b1) begin errors++; $display("FAIL reset_rceb got=%b exp=1", RCEBX); end
        checks++; if (RADDRX !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0000", RADDRX); end
        checks++; if (WBUF_EN !== 1'b0 || WBUF_EN_CTRL !== 6'b0) begin errors++; $display("FAIL reset_en got=%b/%b exp=0/000000", WBUF_EN, WBUF_EN_CTRL); end
        checks++; if (WBUF_BUSY !== 1'b0 || WBUF_DONE !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b/%b exp=0/0", WBUF_BUSY, WBUF_DONE); end
        @(negedge CLK); RSTL = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (RCEBX !== 1'b1 || WBUF_BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b/%b exp=1/0", RCEBX, WBUF_BUSY); end
    endtask

    // Test-1 burst; optionally a second request at T+3 which must be ignored.
    task automatic run_seq(input string nm, input logic resend);
        logic e_rceb, e_en, e_busy, e_done;
        logic [15:0] e_addr;
        logic [5:0]  e_ctrl;
        send(16'h0100, 8'd3, 8'd1, 6'b000101, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            if (k == 1) scramble();
            if (resend && k == 3) begin BASE_ADDR = 16'h0200; COUNT = 8'd2; CH_MASK = 6'b000001; WBUF_SEND = 1'b1; end
            if (k == 4) WBUF_SEND = 1'b0;
            e_rceb = (k > 6);
            e_addr = 16'h0100 + 16'(k - 1);
            e_en   = (k >= 2 && k <= 7);
            e_ctrl = (k >= 2 && k <= 4) ? 6'b000001 : (k >= 5 && k <= 7) ? 6'b000100 : 6'b000000;
            e_busy = (k <= 7);
            e_done = (k == 7);
            checks++; if (RCEBX !== e_rceb) begin errors++; $display("FAIL %s_rceb k=%0d got=%b exp=%b", nm, k, RCEBX, e_rceb); end
            if (!e_rceb) begin checks++; if (RADDRX !== e_addr) begin errors++; $display("FAIL %s_addr k=%0d got=%h exp=%h", nm, k, RADDRX, e_addr); end end
            checks++; if (WBUF_EN !== e_en) begin errors++; $display("FAIL %s_en k=%0d got=%b exp=%b", nm, k, WBUF_EN, e_en); end
            checks++; if (WBUF_EN_CTRL !== e_ctrl) begin errors++; $display("FAIL %s_ctrl k=%0d got=%b exp=%b", nm, k, WBUF_EN_CTRL, e_ctrl); end
            checks++; if (WBUF_BUSY !== e_busy) begin errors++; $display("FAIL %s_busy k=%0d got=%b exp=%b", nm, k, WBUF_BUSY, e_busy); end
            checks++; if (WBUF_DONE !== e_done) begin errors++; $display("FAIL %s_done k=%0d got=%b exp=%b", nm, k, WBUF_DONE, e_done); end
        end
    endtask

    task automatic test_sequential();
        run_seq("seq", 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_seq("ignore", 1'b1);
    endtask

    task automatic test_broadcast();
        logic [15:0] e_addr;
        send(16'h0010, 8'd4, 8'd2, 6'b111111, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge CLK);
            if (k == 1) scramble();
            e_addr = 16'h0010 + 16'(2 * (k - 1));
            checks++; if (RCEBX !== (k > 4)) begin errors++; $display("FAIL bc_rceb k=%0d got=%b exp=%b", k, RCEBX, (k > 4)); end
            if (k <= 4) begin checks++; if (RADDRX !== e_addr) begin errors++; $display("FAIL bc_addr k=%0d got=%h exp=%h", k, RADDRX, e_addr); end end
            checks++; if (WBUF_EN !== (k >= 2 && k <= 5)) begin errors++; $display("FAIL bc_en k=%0d got=%b", k, WBUF_EN); end
            checks++; if (WBUF_EN_CTRL !== ((k >= 2 && k <= 5) ? 6'b111111 : 6'b000000)) begin errors++; $display("FAIL bc_ctrl k=%0d got=%b", k, WBUF_EN_CTRL); end
            checks++; if (WBUF_BUSY !== (k <= 5) || WBUF_DONE !== (k == 5)) begin errors++; $display("FAIL bc_busy_done k=%0d got=%b/%b", k, WBUF_BUSY, WBUF_DONE); end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] tab [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        send(16'hFFFE, 8'd4, 8'd1, 6'b000001, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (k == 1) scramble();
            checks++; if (RCEBX !== (k > 4)) begin errors++; $display("FAIL wrap_rceb k=%0d got=%b exp=%b", k, RCEBX, (k > 4)); end
            if (k <= 4) begin checks++; if (RADDRX !== tab[k-1]) begin errors++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, RADDRX, tab[k-1]); end end
            checks++; if (WBUF_EN_CTRL !== ((k >= 2 && k <= 5) ? 6'b000001 : 6'b000000)) begin errors++; $display("FAIL wrap_ctrl k=%0d got=%b", k, WBUF_EN_CTRL); end
            checks++; if (WBUF_DONE !== (k == 5)) begin errors++; $display("FAIL wrap_done k=%0d got=%b exp=%b", k, WBUF_DONE, (k == 5)); end
        end
    endtask

    // MBUSYX high during T+3 and T+4: reads at T+1..3 and T+6..8, DONE at T+9.
    task automatic test_stall();
        logic [15:0] atab [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0102, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
        logic e_rceb, e_en;
        logic [5:0] e_ctrl;
        int pulses;
        pulses = 0;
        send(16'h0100, 8'd3, 8'd1, 6'b000101, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 1) scramble();
            if (k == 3) MBUSYX = 1'b1;
            if (k == 5) MBUSYX = 1'b0;
            e_rceb = !(k <= 3 || (k >= 6 && k <= 8));
            e_en   = (k >= 2 && k <= 4) || (k >= 7 && k <= 9);
            e_ctrl = (k >= 2 && k <= 4) ? 6'b000001 : (k >= 7 && k <= 9) ? 6'b000100 : 6'b000000;
            if (WBUF_EN === 1'b1) pulses++;
            checks++; if (RCEBX !== e_rceb) begin errors++; $display("FAIL stall_rceb k=%0d got=%b exp=%b", k, RCEBX, e_rceb); end
            if (k <= 8) begin checks++; if (RADDRX !== atab[k-1]) begin errors++; $display("FAIL stall_addr k=%0d got=%h exp=%h", k, RADDRX, atab[k-1]); end end
            checks++; if (WBUF_EN !== e_en || WBUF_EN_CTRL !== e_ctrl) begin errors++; $display("FAIL stall_en k=%0d got=%b/%b exp=%b/%b", k, WBUF_EN, WBUF_EN_CTRL, e_en, e_ctrl); end
            checks++; if (WBUF_BUSY !== (k <= 9) || WBUF_DONE !== (k == 9)) begin errors++; $display("FAIL stall_busy_done k=%0d got=%b/%b", k, WBUF_BUSY, WBUF_DONE); end
        end
        checks++; if (pulses !== 6) begin errors++; $display("FAIL stall_pulses got=%0d exp=6", pulses); end
    endtask

    task automatic test_degenerate();
        for (int v = 0; v < 2; v++) begin
            if (v == 0) send(16'h0100, 8'd0, 8'd1, 6'b000101, 1'b0);
            else        send(16'h0100, 8'd3, 8'd1, 6'b000000, 1'b1);
            for (int k = 1; k <= 3; k++) begin
                @(negedge CLK);
                if (k == 1) scramble();
                checks++; if (RCEBX !== 1'b1 || WBUF_EN !== 1'b0) begin errors++; $display("FAIL degen_read v=%0d k=%0d got=%b/%b exp=1/0", v, k, RCEBX, WBUF_EN); end
                checks++; if (WBUF_BUSY !== (k == 1) || WBUF_DONE !== (k == 1)) begin errors++; $display("FAIL degen_busy_done v=%0d k=%0d got=%b/%b", v, k, WBUF_BUSY, WBUF_DONE); end
            end
        end
    endtask

    task automatic test_purge();
        send(16'h0100, 8'd3, 8'd1, 6'b000101, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) scramble();
            if (k == 3) PURGE = 1'b1;
            if (k == 4) PURGE = 1'b0;
            if (k >= 4) begin
                checks++; if (RCEBX !== 1'b1 || RADDRX !== 16'h0) begin errors++; $display("FAIL purge_read k=%0d got=%b/%h exp=1/0000", k, RCEBX, RADDRX); end
                checks++; if (WBUF_EN !== 1'b0 || WBUF_EN_CTRL !== 6'b0) begin errors++; $display("FAIL purge_en k=%0d got=%b/%b exp=0/000000", k, WBUF_EN, WBUF_EN_CTRL); end
                checks++; if (WBUF_BUSY !== 1'b0 || WBUF_DONE !== 1'b0) begin errors++; $display("FAIL purge_busy_done k=%0d got=%b/%b exp=0/0", k, WBUF_BUSY, WBUF_DONE); end
            end else begin
                checks++; if (WBUF_BUSY !== 1'b1 || RCEBX !== 1'b0) begin errors++; $display("FAIL purge_pre k=%0d got=%b/%b exp=1/0", k, WBUF_BUSY, RCEBX); end
            end
        end
    endtask

    task automatic test_async_reset();
        send(16'h0100, 8'd3, 8'd1, 6'b000101, 1'b0);
        repeat (3) @(negedge CLK);
        WBUF_SEND = 1'b0;
        checks++; if (WBUF_EN !== 1'b1 || RCEBX !== 1'b0) begin errors++; $display("FAIL arst_pre got=%b/%b exp=1/0", WBUF_EN, RCEBX); end
        #2 RSTL = 1'b0;
        #1;
        checks++; if (RCEBX !== 1'b1 || RADDRX !== 16'h0) begin errors++; $display("FAIL arst_read got=%b/%h exp=1/0000", RCEBX, RADDRX); end
        checks++; if (WBUF_EN !== 1'b0 || WBUF_EN_CTRL !== 6'b0) begin errors++; $display("FAIL arst_en got=%b/%b exp=0/000000", WBUF_EN, WBUF_EN_CTRL); end
        checks++; if (WBUF_BUSY !== 1'b0 || WBUF_DONE !== 1'b0) begin errors++; $display("FAIL arst_busy_done got=%b/%b exp=0/0", WBUF_BUSY, WBUF_DONE); end
        @(negedge CLK); RSTL = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            checks++; if (RCEBX !== 1'b1 || WBUF_BUSY !== 1'b0 || WBUF_EN !== 1'b0) begin errors++; $display("FAIL arst_idle got=%b/%b/%b exp=1/0/0", RCEBX, WBUF_BUSY, WBUF_EN); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_broadcast();
        test_wrap();
        test_stall();
        test_degenerate();
        test_busy_ignore();
        test_purge();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
